// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants for the instruction fetch queue.
package riscv_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fq_entry_ram.sv
// Entry storage for the fetch queue: PC is written when the request is
// granted, the instruction word when its response returns; one async read.
module fq_entry_ram
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               pc_we,
  input  logic [AW-1:0]      pc_waddr,
  input  logic [WIDTH-1:0]   pc_wdata,
  input  logic               data_we,
  input  logic [AW-1:0]      data_waddr,
  input  logic [INSTR_W-1:0] data_wdata,
  input  logic [AW-1:0]      rd_addr,
  output logic [WIDTH-1:0]   rd_pc,
  output logic [INSTR_W-1:0] rd_instr
);

  logic [WIDTH-1:0]   pc_mem   [DEPTH];
  logic [INSTR_W-1:0] instr_mem[DEPTH];

  // Two independent write ports; the array holds data only, so no reset.
  always_ff @(posedge clk) begin
    if (pc_we)   pc_mem[pc_waddr]      <= pc_wdata;
    if (data_we) instr_mem[data_waddr] <= data_wdata;
  end

  assign rd_pc    = pc_mem[rd_addr];
  assign rd_instr = instr_mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues PCs to instruction memory under a credit
// limit, collects in-order responses and hands {pc, instr} to decode.
// A flush empties the queue and discards every response still in flight.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               pc_valid,
  input  logic [WIDTH-1:0]   pc,
  output logic               pc_ready,
  output logic               imem_req,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [WIDTH-1:0]   instr_pc,
  input  logic               instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;   // extra MSB is the wrap bit
  localparam int CW = PW + 1;   // headroom for credit / drop sums

  logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr, drop_cnt;
  logic [PW-1:0] occupancy, unfilled;
  logic [CW-1:0] drop_sum;
  logic          credit, grant, fill_now, drop_now, consume;
  logic [WIDTH-1:0]   rd_pc;
  logic [INSTR_W-1:0] rd_instr;

  // Occupancy counts granted-but-unconsumed entries; dropped responses still
  // hold memory-side slots, so they count against credit too.
  assign occupancy = alloc_ptr - rd_ptr;
  assign unfilled  = alloc_ptr - fill_ptr;
  assign credit    = ({1'b0, occupancy} + {1'b0, drop_cnt}) < CW'(DEPTH);

  assign imem_req  = pc_valid & credit & ~flush & ~rst;
  assign imem_addr = pc;
  assign grant     = imem_req & imem_gnt;
  assign pc_ready  = grant;

  // A response in the flush cycle is always discarded, whichever group it
  // belongs to: stale (drop_cnt != 0) or the oldest live request.
  assign drop_now  = imem_rvalid & (drop_cnt != '0);
  assign fill_now  = imem_rvalid & (drop_cnt == '0) & ~flush;

  assign instr_valid = (fill_ptr != rd_ptr);
  assign consume     = instr_valid & instr_ready & ~flush;
  assign instr       = instr_valid ? rd_instr : '0;
  assign instr_pc    = instr_valid ? rd_pc    : '0;

  // Responses still owed after a flush: old drops plus every unfilled grant,
  // less the one response retired this cycle.
  always_comb begin
    drop_sum = {1'b0, drop_cnt} + {1'b0, unfilled} - CW'(imem_rvalid);
  end

  // Pointer and drop-counter update; reset outranks flush and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= drop_sum[PW-1:0];
    end else begin
      alloc_ptr <= alloc_ptr + PW'(grant);
      fill_ptr  <= fill_ptr + PW'(fill_now);
      rd_ptr    <= rd_ptr + PW'(consume);
      drop_cnt  <= drop_cnt - PW'(drop_now);
    end
  end

  // Protocol checks: no unsolicited response, no drop-counter overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && (alloc_ptr == fill_ptr) && (drop_cnt == '0)));
      assert (!flush || (drop_sum <= CW'(DEPTH)));
    end
  end

  fq_entry_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk        (clk),
    .pc_we      (grant),
    .pc_waddr   (alloc_ptr[AW-1:0]),
    .pc_wdata   (pc),
    .data_we    (fill_now),
    .data_waddr (fill_ptr[AW-1:0]),
    .data_wdata (imem_rdata),
    .rd_addr    (rd_ptr[AW-1:0]),
    .rd_pc      (rd_pc),
    .rd_instr   (rd_instr)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: behavioural memory + queue model, per-cycle compare.
module tb_fetch_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, pc_valid, pc_ready, imem_req, imem_gnt;
  logic        imem_rvalid, instr_valid, instr_ready;
  logic [31:0] pc, imem_addr, imem_rdata, instr, instr_pc;

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pc_valid(pc_valid), .pc(pc),
    .pc_ready(pc_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // Outstanding memory requests in issue order; dropped = belongs to a flushed stream.
  typedef struct { logic [31:0] pc; int due; bit dropped; } req_t;
  // Filled queue entries awaiting decode.
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  req_t mem_q[$];
  ent_t out_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, serial = 0;
  bit model_on = 0;
  logic s_rst = 1, s_flush = 0, s_pc_valid = 0, s_gnt = 0, s_ready = 0;
  logic [31:0] s_pc = 0;
  int dly_lo = 1, dly_hi = 1;

  logic [31:0] grant_pcs[$];
  int          grant_cyc[$];
  logic [31:0] pres_pcs[$];
  int          pres_cyc[$];
  logic        snap_req, snap_vld;
  logic [31:0] snap_instr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    grant_pcs.delete(); grant_cyc.delete(); pres_pcs.delete(); pres_cyc.delete();
  endtask

  // One clock: drive at negedge, compare #1 later, advance model at posedge.
  task automatic step();
    logic        e_req, e_vld, a_grant, rv;
    logic [31:0] rd, hpc;
    ent_t        e;
    req_t        h;
    @(negedge clk);
    rst = s_rst; flush = s_flush; pc_valid = s_pc_valid; pc = s_pc;
    imem_gnt = s_gnt; instr_ready = s_ready;
    rv = 1'b0; rd = '0;
    if (!s_rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rv  = 1'b1;
      hpc = mem_q[0].pc;
      rd  = {hpc[15:0] ^ 16'hC3A5, serial[15:0]};
    end
    imem_rvalid = rv; imem_rdata = rd;
    #1;
    e_req = !s_rst && s_pc_valid && !s_flush && (out_q.size() + mem_q.size() < DEPTH);
    e_vld = (out_q.size() > 0);
    snap_req = imem_req; snap_vld = instr_valid; snap_instr = instr;
    if (model_on) begin
      chk("imem_req", 64'(imem_req), 64'(e_req));
      chk("pc_ready", 64'(pc_ready), 64'(e_req & s_gnt));
      chk("imem_addr", 64'(imem_addr), 64'(s_pc));
      chk("instr_valid", 64'(instr_valid), 64'(e_vld));
      chk("instr", 64'(instr), e_vld ? 64'(out_q[0].data) : 64'h0);
      chk("instr_pc", 64'(instr_pc), e_vld ? 64'(out_q[0].pc) : 64'h0);
    end
    a_grant = (imem_req === 1'b1) && s_gnt;
    if (a_grant) begin grant_pcs.push_back(s_pc); grant_cyc.push_back(cyc); end
    if (instr_valid === 1'b1 && s_ready && !s_flush && !s_rst) begin
      pres_pcs.push_back(instr_pc); pres_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (s_rst) begin
      mem_q.delete(); out_q.delete(); model_on = 1;
    end else begin
      if (s_flush) begin
        if (rv) void'(mem_q.pop_front());
        foreach (mem_q[i]) mem_q[i].dropped = 1;
        out_q.delete();
      end else begin
        if (out_q.size() > 0 && s_ready) void'(out_q.pop_front());
        if (rv) begin
          h = mem_q.pop_front();
          if (!h.dropped) begin e.pc = h.pc; e.data = rd; out_q.push_back(e); end
        end
      end
      if (rv) serial++;
      if (a_grant) begin
        h.pc = s_pc; h.due = cyc + $urandom_range(dly_hi, dly_lo); h.dropped = 0;
        mem_q.push_back(h);
        s_pc = s_pc + 4;
      end
      if (model_on) chk("credit_cap", 64'(mem_q.size() + out_q.size() <= DEPTH), 64'h1);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1; flush = 0; pc_valid = 0; pc = 0; imem_gnt = 0;
    imem_rvalid = 0; imem_rdata = 0; instr_ready = 0;

    // Reset with a pending fetch request
    s_rst = 1; s_pc_valid = 1; s_gnt = 1;
    idle(2);
    chk("rst_req", 64'(snap_req), 64'h0);
    chk("rst_vld", 64'(snap_vld), 64'h0);
    chk("rst_instr", 64'(snap_instr), 64'h0);
    s_rst = 0; s_pc_valid = 0;
    idle(1);

    // Streaming, one response per cycle one cycle after grant
    clear_logs();
    dly_lo = 1; dly_hi = 1; s_pc = 0; s_pc_valid = 1; s_gnt = 1; s_ready = 1;
    idle(10);
    s_pc_valid = 0;
    idle(4);
    chk("stream_count", 64'(pres_pcs.size() >= 3), 64'h1);
    if (pres_pcs.size() >= 3 && grant_cyc.size() >= 1) begin
      chk("stream_pc0", 64'(pres_pcs[0]), 64'h0);
      chk("stream_pc1", 64'(pres_pcs[1]), 64'h4);
      chk("stream_pc2", 64'(pres_pcs[2]), 64'h8);
      chk("stream_latency", 64'(pres_cyc[0] - grant_cyc[0]), 64'd2);
      chk("stream_rate", 64'(pres_cyc[2] - pres_cyc[0]), 64'd2);
    end

    // Back-pressure: four grants fill the queue, one consume frees one slot
    clear_logs();
    s_pc = 0; s_pc_valid = 1; s_ready = 0;
    idle(10);
    chk("bp_grants", 64'(grant_pcs.size()), 64'd4);
    if (grant_pcs.size() == 4) chk("bp_last_pc", 64'(grant_pcs[3]), 64'hC);
    chk("bp_req_off", 64'(snap_req), 64'h0);
    s_ready = 1; idle(1);
    s_ready = 0; idle(5);
    chk("bp_regrant", 64'(grant_pcs.size()), 64'd5);
    if (grant_pcs.size() == 5) chk("bp_regrant_pc", 64'(grant_pcs[4]), 64'h10);
    s_pc_valid = 0; s_ready = 1;
    idle(8);

    // Flush with two requests still in flight
    clear_logs();
    dly_lo = 3; dly_hi = 3; s_pc = 32'h100; s_pc_valid = 1;
    idle(2);
    s_pc_valid = 0; s_flush = 1; idle(1);
    s_flush = 0; idle(4);
    s_pc = 32'h200; s_pc_valid = 1; idle(1);
    s_pc_valid = 0; idle(6);
    chk("fl_grants", 64'(grant_pcs.size()), 64'd3);
    chk("fl_presented", 64'(pres_pcs.size()), 64'd1);
    if (pres_pcs.size() == 1) chk("fl_pc", 64'(pres_pcs[0]), 64'h200);
    chk("fl_drop_cnt", 64'(dut.drop_cnt), 64'h0);

    // Flush and response in the same cycle
    clear_logs();
    dly_lo = 1; dly_hi = 1; s_pc = 32'h300; s_pc_valid = 1; idle(1);
    s_pc_valid = 0; s_flush = 1; idle(1);
    s_flush = 0; idle(1);
    chk("flrv_vld", 64'(snap_vld), 64'h0);
    chk("flrv_drop_cnt", 64'(dut.drop_cnt), 64'h0);
    s_pc = 32'h400; s_pc_valid = 1; idle(1);
    s_pc_valid = 0; idle(4);
    chk("flrv_presented", 64'(pres_pcs.size()), 64'd1);
    if (pres_pcs.size() == 1) chk("flrv_pc", 64'(pres_pcs[0]), 64'h400);

    // Randomised traffic with periodic flushes and one mid-burst reset
    clear_logs();
    dly_lo = 1; dly_hi = 5;
    for (int i = 0; i < 10000; i++) begin
      s_pc_valid = ($urandom_range(9) < 8);
      s_gnt      = ($urandom_range(9) < 7);
      s_ready    = ($urandom_range(9) < 6);
      s_flush    = ($urandom_range(49) == 0) || (i % 397 == 200);
      s_rst      = (i == 5000);
      if (s_flush) s_pc = $urandom() & 32'hFFFF_FFFC;
      step();
    end
    s_rst = 0; s_flush = 0; s_pc_valid = 0; s_ready = 1;
    idle(12);
    chk("rand_activity", 64'(pres_pcs.size() > 500), 64'h1);
    chk("rand_drained", 64'(instr_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
